serial_bus_unit: RTL and testbench
==================================

Name: serial_bus_unit

Overview:
- Parametrised external-bus interface for the serial CPU. Serialises DATA_W-bit words from NUM_CH internal sources (PC, MDR, MAR, ...) onto a BUS_W-bit output bus, and deserialises inbound BUS_W-bit beats into DATA_W-bit words.
- Generalises the fixed 16-bit/8-bit, three-source bus mux and shift registers with arbitration, handshakes, backpressure and overrun detection.
- Sits between the core datapath and the external microcontroller link.

Parameters:
- DATA_W, 16, word width; must be an integer multiple of BUS_W (elaboration error otherwise).
- BUS_W, 8, external bus width.
- NUM_CH, 3, number of transmit sources.
- BEATS (local), DATA_W/BUS_W, beats per word.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tx_req  in  NUM_CH  per-channel send request; held until granted
- tx_data  in  NUM_CH*DATA_W  channel i word at [i*DATA_W +: DATA_W]
- tx_grant  out  NUM_CH  one-hot, one-cycle pulse: word accepted
- tx_done  out  1  one-cycle pulse: last beat accepted
- busy  out  1  transmit in progress
- bus_sel  out  NUM_CH  one-hot owner of out_bus; 0 when idle
- out_bus  out  BUS_W  current transmit beat
- ard_receive_ready  in  1  external side accepts current out_bus beat this cycle
- ard_data_ready  in  1  in_bus carries a valid beat this cycle
- in_bus  in  BUS_W  inbound beat
- rx_data  out  DATA_W  assembled word
- rx_valid  out  1  rx_data valid; held until rx_ack
- rx_ack  in  1  consumer takes rx_data
- rx_overrun  out  1  sticky: a completed word was dropped
- abort  in  1  cancel in-flight transfers (halt)

Behaviour:
- Reset: all outputs 0; tx FSM in IDLE; beat counters 0; rx_overrun cleared. Reset in mid-operation discards all partial state.
- Tx FSM, states IDLE and SEND.
  - IDLE with any tx_req: the arbiter picks a channel (fixed priority, lowest index wins). At that edge tx_data is latched and the FSM enters SEND.
  - tx_grant is one-hot for that channel during the first SEND cycle only.
  - SEND: out_bus = current beat, MSB beat first; bus_sel is one-hot for the owner; busy=1.
  - Beat counter advances only on cycles with ard_receive_ready=1. Otherwise out_bus holds its value (backpressure, unbounded).
  - When the last beat is accepted, the FSM returns to IDLE and tx_done pulses in that next (IDLE) cycle. A new request may be accepted in that same cycle, so the minimum inter-word gap is 1 cycle.
  - Outside SEND, out_bus=0 and bus_sel=0.
- Rx path: independent of tx.
  - Each cycle with ard_data_ready=1 shifts in_bus into the assembler, MSB beat first.
  - On the BEATS-th beat the word completes and the counter wraps to 0.
  - On completion with rx_valid=0, or with rx_valid=1 and rx_ack=1 in the same cycle: rx_data is updated and rx_valid=1 from the next cycle.
  - On completion with rx_valid=1 and rx_ack=0: the word is dropped, rx_data is unchanged, and rx_overrun is set (stays set until rst).
  - rx_ack with rx_valid=1 and no completion clears rx_valid next cycle. rx_ack with rx_valid=0 is ignored.
- abort (priority below rst, above everything else):
  - Tx FSM goes to IDLE; no tx_done; no grant that cycle.
  - Rx partial beat counter cleared; rx_valid, rx_data and rx_overrun are preserved.
- BEATS=1: SEND lasts exactly one accepted beat; every rx beat completes a word.

Optional Feature:
- Macro SBU_RR_ARB_EN.
  - Defined: round-robin arbitration. The search starts at the channel after the last granted one. The pointer updates on each grant and resets to channel 0.
  - Undefined: fixed priority, lowest index wins.

Test Plan (DATA_W=16, BUS_W=8, NUM_CH=3):
- tx_req=3'b010, ch1 data 0xBEEF, ard_receive_ready=1 -> tx_grant=010 for 1 cycle; out_bus 0xBE then 0xEF with bus_sel=010; tx_done pulses 1 cycle later; bus_sel=0.
- As above, but ard_receive_ready=0 for 3 cycles after the first beat -> out_bus holds 0xEF for 3 cycles; tx_done is delayed by 3 cycles.
- tx_req=3'b101 held continuously, ch0=0x1111, ch2=0x2222 -> fixed priority: ch0 starves ch2. With SBU_RR_ARB_EN: 0x1111, then 0x2222, then 0x1111.
- in_bus 0x12, 0x34 with ard_data_ready, no ack -> rx_data=0x1234, rx_valid=1. Then 0x56, 0x78 -> rx_overrun=1, rx_data still 0x1234. rx_ack -> rx_valid=0.
- Start ch0 0xABCD, accept one beat, then abort=1 -> busy=0, bus_sel=0, no tx_done. Also rx beat 0x99 then abort, then 0xAB, 0xCD -> rx_data=0xABCD.
- rst asserted after one rx beat and mid-SEND -> all outputs 0 next cycle, including rx_overrun; a subsequent 0xAB, 0xCD assembles to 0xABCD.

Source files
------------

// File: rtl/serial_bus_unit.sv
// serial_bus_unit: external-bus interface for the serial CPU.
// Serialises DATA_W-bit words from NUM_CH sources onto a BUS_W-bit bus, MSB beat first,
// and assembles inbound BUS_W-bit beats into DATA_W-bit words.
// Optional feature macro: SBU_RR_ARB_EN selects round-robin arbitration
// (default: fixed priority, lowest channel index wins).
module serial_bus_unit #(
   parameter int DATA_W = 16,
   parameter int BUS_W  = 8,
   parameter int NUM_CH = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        tx_req,
   input  logic [NUM_CH*DATA_W-1:0] tx_data,
   output logic [NUM_CH-1:0]        tx_grant,
   output logic                     tx_done,
   output logic                     busy,
   output logic [NUM_CH-1:0]        bus_sel,
   output logic [BUS_W-1:0]         out_bus,
   input  logic                     ard_receive_ready,
   input  logic                     ard_data_ready,
   input  logic [BUS_W-1:0]         in_bus,
   output logic [DATA_W-1:0]        rx_data,
   output logic                     rx_valid,
   input  logic                     rx_ack,
   output logic                     rx_overrun,
   input  logic                     abort
);

   localparam int BEATS = DATA_W / BUS_W;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   if ((BUS_W < 1) || (DATA_W < BUS_W) || ((DATA_W % BUS_W) != 0)) begin : g_bad_width
      $error("serial_bus_unit: DATA_W must be a positive integer multiple of BUS_W");
   end

   typedef enum logic {IDLE, SEND} tx_state_t;

   tx_state_t            state, state_next;
   logic [NUM_CH-1:0]    pick;
   logic [DATA_W-1:0]    load_word;
   logic [DATA_W-1:0]    tx_shift;
   logic [CW-1:0]        tx_cnt;
   logic [NUM_CH-1:0]    owner;
   logic                 tx_first;
   logic                 load, shift_beat, finish;

   logic [DATA_W-1:0]    rx_asm, rx_asm_next;
   logic [CW-1:0]        rx_cnt;
   logic                 rx_complete;

   // Isolate the lowest set bit (two's-complement trick).
   function automatic logic [NUM_CH-1:0] lowest_one(input logic [NUM_CH-1:0] v);
      return v & (~v + NUM_CH'(1));
   endfunction

`ifdef SBU_RR_ARB_EN
   logic [NUM_CH-1:0] rr_mask;
   logic [NUM_CH-1:0] req_hi;

   // Round-robin pick: prefer requesters above the last grant, else wrap to the lowest.
   always_comb begin
      req_hi = tx_req & rr_mask;
      pick   = (|req_hi) ? lowest_one(req_hi) : lowest_one(tx_req);
   end

   // Remember which channels rank above the last grant; all of them after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_mask <= '1;
      end else if (load) begin
         rr_mask <= ~((pick << 1) - NUM_CH'(1));
      end
   end
`else
   // Fixed-priority pick: lowest requesting channel wins.
   always_comb begin
      pick = lowest_one(tx_req);
   end
`endif

   // Select the word of the picked channel.
   always_comb begin
      load_word = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (pick[k]) begin
            load_word = load_word | tx_data[k*DATA_W +: DATA_W];
         end
      end
   end

   // Tx state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Tx next-state and bus outputs; abort overrides any transition in flight.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      shift_beat = 1'b0;
      finish     = 1'b0;
      busy       = 1'b0;
      bus_sel    = '0;
      out_bus    = '0;
      tx_grant   = '0;
      case (state)
         IDLE: begin
            if (|tx_req) begin
               state_next = SEND;
               load       = 1'b1;
            end
         end
         SEND: begin
            busy    = 1'b1;
            bus_sel = owner;
            out_bus = tx_shift[DATA_W-1 -: BUS_W];
            if (tx_first) begin
               tx_grant = owner;
            end
            if (ard_receive_ready) begin
               if (tx_cnt == LAST_BEAT) begin
                  state_next = IDLE;
                  finish     = 1'b1;
               end else begin
                  shift_beat = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      if (abort) begin
         state_next = IDLE;
         load       = 1'b0;
         shift_beat = 1'b0;
         finish     = 1'b0;
         tx_grant   = '0;
      end
   end

   // Tx datapath: latch the word on grant, shift out one beat per accepted cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_shift <= '0;
         tx_cnt   <= '0;
         owner    <= '0;
         tx_first <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         tx_first <= load;
         tx_done  <= finish;
         if (load) begin
            tx_shift <= load_word;
            tx_cnt   <= '0;
            owner    <= pick;
         end else if (shift_beat) begin
            tx_shift <= tx_shift << BUS_W;
            tx_cnt   <= tx_cnt + 1'b1;
         end else if (finish || abort) begin
            tx_cnt <= '0;
            owner  <= '0;
         end
      end
   end

   // Rx assembler input: shift in the new beat and detect word completion.
   always_comb begin
      rx_asm_next = (rx_asm << BUS_W) | DATA_W'(in_bus);
      rx_complete = ard_data_ready && (rx_cnt == LAST_BEAT) && !abort;
   end

   // Rx path: assemble, hand off or drop completed words, track overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_asm     <= '0;
         rx_cnt     <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
      end else if (abort) begin
         rx_cnt <= '0;
      end else begin
         if (ard_data_ready) begin
            rx_asm <= rx_asm_next;
            rx_cnt <= (rx_cnt == LAST_BEAT) ? '0 : rx_cnt + 1'b1;
         end
         if (rx_complete) begin
            if (!rx_valid || rx_ack) begin
               rx_data  <= rx_asm_next;
               rx_valid <= 1'b1;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (rx_ack) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_bus_unit.sv
// Directed testbench for serial_bus_unit (DATA_W=16, BUS_W=8, NUM_CH=3).
// Honours SBU_RR_ARB_EN when choosing the expected arbitration order.
module tb_serial_bus_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  tx_req;
   logic [47:0] tx_data;
   logic [2:0]  tx_grant;
   logic        tx_done;
   logic        busy;
   logic [2:0]  bus_sel;
   logic [7:0]  out_bus;
   logic        ard_receive_ready;
   logic        ard_data_ready;
   logic [7:0]  in_bus;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        rx_ack;
   logic        rx_overrun;
   logic        abort;

   int checkCount = 0;
   int passCount  = 0;

   serial_bus_unit #(.DATA_W(16), .BUS_W(8), .NUM_CH(3)) dut (
      .clk(clk), .rst(rst),
      .tx_req(tx_req), .tx_data(tx_data), .tx_grant(tx_grant), .tx_done(tx_done),
      .busy(busy), .bus_sel(bus_sel), .out_bus(out_bus),
      .ard_receive_ready(ard_receive_ready), .ard_data_ready(ard_data_ready),
      .in_bus(in_bus), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
      .rx_overrun(rx_overrun), .abort(abort)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Drive one cycle of inputs, let the edge happen, then settle before sampling.
   task automatic applyStimulus(input logic [2:0] req, input logic rdy, input logic dr,
                                input logic [7:0] inb, input logic ack, input logic ab);
      tx_req            = req;
      ard_receive_ready = rdy;
      ard_data_ready    = dr;
      in_bus            = inb;
      rx_ack            = ack;
      abort             = ab;
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   // All outputs must be zero right after reset.
   task automatic checkAllZero(input string tag);
      checkOutput({tag, " busy"},       32'(busy),       32'h0);
      checkOutput({tag, " bus_sel"},    32'(bus_sel),    32'h0);
      checkOutput({tag, " out_bus"},    32'(out_bus),    32'h0);
      checkOutput({tag, " tx_grant"},   32'(tx_grant),   32'h0);
      checkOutput({tag, " tx_done"},    32'(tx_done),    32'h0);
      checkOutput({tag, " rx_valid"},   32'(rx_valid),   32'h0);
      checkOutput({tag, " rx_data"},    32'(rx_data),    32'h0);
      checkOutput({tag, " rx_overrun"}, 32'(rx_overrun), 32'h0);
   endtask

   // Directed sequence.
   initial begin
      logic [2:0] expGrant [3];
      logic [7:0] expBeat  [3];
`ifdef SBU_RR_ARB_EN
      expGrant = '{3'b001, 3'b100, 3'b001};
      expBeat  = '{8'h11, 8'h22, 8'h11};
`else
      expGrant = '{3'b001, 3'b001, 3'b001};
      expBeat  = '{8'h11, 8'h11, 8'h11};
`endif
      rst     = 1'b1;
      tx_data = '0;
      applyStimulus(3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulus(3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      checkAllZero("reset");
      rst = 1'b0;

      $display("[TB] basic transmit ch1 0xBEEF");
      tx_data = {16'h0000, 16'hBEEF, 16'h0000};
      applyStimulus(3'b010, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t1 grant", 32'(tx_grant), 32'h2);
      checkOutput("t1 beat0", 32'(out_bus), 32'hBE);
      checkOutput("t1 sel0", 32'(bus_sel), 32'h2);
      checkOutput("t1 busy0", 32'(busy), 32'h1);
      applyStimulus(3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t1 beat1", 32'(out_bus), 32'hEF);
      checkOutput("t1 grant1", 32'(tx_grant), 32'h0);
      checkOutput("t1 sel1", 32'(bus_sel), 32'h2);
      applyStimulus(3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t1 done", 32'(tx_done), 32'h1);
      checkOutput("t1 sel idle", 32'(bus_sel), 32'h0);
      checkOutput("t1 busy idle", 32'(busy), 32'h0);
      checkOutput("t1 bus idle", 32'(out_bus), 32'h0);
      applyStimulus(3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t1 done pulse", 32'(tx_done), 32'h0);

      $display("[TB] transmit with backpressure");
      applyStimulus(3'b010, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t2 beat0", 32'(out_bus), 32'hBE);
      applyStimulus(3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t2 beat1", 32'(out_bus), 32'hEF);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
         checkOutput("t2 hold bus", 32'(out_bus), 32'hEF);
         checkOutput("t2 hold busy", 32'(busy), 32'h1);
         checkOutput("t2 hold done", 32'(tx_done), 32'h0);
      end
      applyStimulus(3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t2 done", 32'(tx_done), 32'h1);

      $display("[TB] arbitration with ch0 and ch2 held");
      rst = 1'b1;
      applyStimulus(3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      tx_data = {16'h2222, 16'h0000, 16'h1111};
      for (int w = 0; w < 3; w++) begin
         applyStimulus(3'b101, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
         checkOutput("t3 grant", 32'(tx_grant), 32'(expGrant[w]));
         checkOutput("t3 beat0", 32'(out_bus), 32'(expBeat[w]));
         applyStimulus(3'b101, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
         checkOutput("t3 beat1", 32'(out_bus), 32'(expBeat[w]));
         applyStimulus(3'b101, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
         checkOutput("t3 done", 32'(tx_done), 32'h1);
         checkOutput("t3 gap busy", 32'(busy), 32'h0);
      end
      applyStimulus(3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t3 idle busy", 32'(busy), 32'h0);

      $display("[TB] receive, overrun, ack");
      applyStimulus(3'b000, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
      checkOutput("t4 half valid", 32'(rx_valid), 32'h0);
      applyStimulus(3'b000, 1'b0, 1'b1, 8'h34, 1'b0, 1'b0);
      checkOutput("t4 data", 32'(rx_data), 32'h1234);
      checkOutput("t4 valid", 32'(rx_valid), 32'h1);
      checkOutput("t4 no overrun", 32'(rx_overrun), 32'h0);
      applyStimulus(3'b000, 1'b0, 1'b1, 8'h56, 1'b0, 1'b0);
      applyStimulus(3'b000, 1'b0, 1'b1, 8'h78, 1'b0, 1'b0);
      checkOutput("t4 overrun", 32'(rx_overrun), 32'h1);
      checkOutput("t4 data kept", 32'(rx_data), 32'h1234);
      checkOutput("t4 valid kept", 32'(rx_valid), 32'h1);
      applyStimulus(3'b000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("t4 ack clears", 32'(rx_valid), 32'h0);
      checkOutput("t4 overrun sticky", 32'(rx_overrun), 32'h1);
      applyStimulus(3'b000, 1'b0, 1'b1, 8'h9A, 1'b0, 1'b0);
      applyStimulus(3'b000, 1'b0, 1'b1, 8'hBC, 1'b0, 1'b0);
      checkOutput("t4 data2", 32'(rx_data), 32'h9ABC);
      applyStimulus(3'b000, 1'b0, 1'b1, 8'hDE, 1'b0, 1'b0);
      checkOutput("t4 valid held", 32'(rx_valid), 32'h1);
      applyStimulus(3'b000, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0);
      checkOutput("t4 ack+complete data", 32'(rx_data), 32'hDEF0);
      checkOutput("t4 ack+complete valid", 32'(rx_valid), 32'h1);
      applyStimulus(3'b000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("t4 ack2", 32'(rx_valid), 32'h0);

      $display("[TB] abort tx and rx");
      tx_data = {16'h0000, 16'h0000, 16'hABCD};
      applyStimulus(3'b001, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t5 beat0", 32'(out_bus), 32'hAB);
      applyStimulus(3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t5 beat1", 32'(out_bus), 32'hCD);
      applyStimulus(3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("t5 busy", 32'(busy), 32'h0);
      checkOutput("t5 sel", 32'(bus_sel), 32'h0);
      checkOutput("t5 done", 32'(tx_done), 32'h0);
      applyStimulus(3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t5 no done", 32'(tx_done), 32'h0);
      applyStimulus(3'b000, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
      applyStimulus(3'b000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      checkOutput("t5 rx data kept", 32'(rx_data), 32'hDEF0);
      checkOutput("t5 overrun kept", 32'(rx_overrun), 32'h1);
      applyStimulus(3'b000, 1'b0, 1'b1, 8'hAB, 1'b0, 1'b0);
      checkOutput("t5 partial", 32'(rx_valid), 32'h0);
      applyStimulus(3'b000, 1'b0, 1'b1, 8'hCD, 1'b0, 1'b0);
      checkOutput("t5 rx data", 32'(rx_data), 32'hABCD);
      checkOutput("t5 rx valid", 32'(rx_valid), 32'h1);

      $display("[TB] reset mid-operation");
      applyStimulus(3'b000, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
      tx_data = {16'h0000, 16'hBEEF, 16'h0000};
      applyStimulus(3'b010, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t6 sending", 32'(busy), 32'h1);
      rst = 1'b1;
      applyStimulus(3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      checkAllZero("t6 reset");
      rst = 1'b0;
      applyStimulus(3'b000, 1'b0, 1'b1, 8'hAB, 1'b0, 1'b0);
      checkOutput("t6 partial", 32'(rx_valid), 32'h0);
      applyStimulus(3'b000, 1'b0, 1'b1, 8'hCD, 1'b0, 1'b0);
      checkOutput("t6 rx data", 32'(rx_data), 32'hABCD);
      checkOutput("t6 rx valid", 32'(rx_valid), 32'h1);
      checkOutput("t6 overrun", 32'(rx_overrun), 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
